uart_rx_path: RTL
=================

Name: uart_rx_path

Overview:
Receive-side counterpart of the UART transmit path. It integrates a programmable baud-tick timer, a 2-flop input synchronizer, a 16x-oversampling UART receiver FSM and a receive FIFO. The block takes the serial line `rx` and delivers received bytes to the host through a FIFO read interface with full/empty flags. It also reports framing errors and overruns.

Parameters:
bit, 10, width of input_number (baud divisor)
D_bit, 8, data bits per frame
stop_tick, 16, s_ticks spent in the stop bit (16 = 1 stop bit)
depth, 8, FIFO depth in words (power of 2, ≥2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
input_number  input  bit  baud divisor; s_tick period = input_number+1 clocks
rx  input  1  serial line, idle high, asynchronous to clk
read_en  input  1  pop one FIFO word (ignored when empty)
read_data  output  D_bit  FIFO head word, first-word-fall-through
empty  output  1  FIFO holds 0 words
full  output  1  FIFO holds depth words
frame_err  output  1  1-clock pulse: stop bit sampled low
overrun  output  1  1-clock pulse: byte completed while FIFO full, byte dropped

Behaviour:
- Reset (async, rst=1) sets:
  - timer count 0; synchronizer flops to 1; FSM to IDLE; s/n/shift registers 0.
  - FIFO pointers and count 0.
  - Outputs: empty=1, full=0, frame_err=0, overrun=0, read_data=0.
- Reset asserted mid-frame aborts the frame; the partial byte is never written.
- Timer:
  - Free-running counter from 0 to input_number, then wraps to 0.
  - s_tick=1 for the single clock where count==input_number.
  - input_number=0 gives s_tick every clock.
  - A divisor change takes effect at the next compare.
- Synchronizer: rx_s = rx delayed 2 clocks. The FSM sees only rx_s.
- FSM states: IDLE, START, DATA, STOP. Counter s counts s_ticks; counter n counts data bits.
  - IDLE: on rx_s==0 -> START, s=0. No s_tick needed to leave IDLE.
  - START: on s_tick, if s==7 (mid start bit):
    - rx_s==1 -> IDLE (glitch rejected, nothing written).
    - else -> DATA, s=0, n=0.
    - Otherwise s++.
  - DATA: on s_tick, if s==15:
    - shift = {rx_s, shift[D_bit-1:1]} (LSB first), s=0.
    - if n==D_bit-1 -> STOP, else n++.
    - Otherwise s++.
  - STOP: on s_tick, if s==stop_tick-1:
    - rx_s==1 -> rx_done (1-clock strobe), data = shift.
    - rx_s==0 -> frame_err pulse, byte discarded.
    - Either way -> IDLE. Otherwise s++.
  - A new frame may begin on the clock after returning to IDLE.
- FIFO write on rx_done:
  - Not full: mem[wr_ptr] = shift, wr_ptr++ (wraps mod depth).
  - Full without same-cycle read: byte dropped, overrun pulses in the same clock as the would-be write, FIFO unchanged.
- FIFO read:
  - read_data = mem[rd_ptr] combinationally; valid only when empty=0.
  - read_en with empty=0 advances rd_ptr. read_en while empty is ignored.
- Simultaneous events:
  - Write+read while full: both occur, count unchanged, no overrun.
  - Write+read while empty: write occurs, read ignored, empty deasserts next clock.
  - Otherwise count changes by +1/-1/0.
- Flags are registered from count: full = (count==depth), empty = (count==0). Both update the clock after the causing edge.

Test Plan:
- Single byte: input_number=9 (1 bit = 160 clks), send 8'hA5 frame 0-10100101(LSB first)-1 -> one write ~ (9.5×160+2) clks after start edge; empty 1->0; read_data=8'hA5; read_en pop -> empty=1; frame_err=0, overrun=0.
- False start: rx low 40 clks (< half bit) then high, input_number=9 -> FSM returns IDLE; empty stays 1; no flags.
- Framing error: send 8'h3C with stop bit low -> frame_err pulses exactly once; FIFO unchanged (empty=1); next good frame 8'h55 received correctly.
- Fill/overrun: send 9 bytes 8'h01..8'h09, no reads -> full=1 after 8th; 9th gives one overrun pulse; reads return 01..08 in order, then empty=1.
- Simultaneous: FIFO full, assert read_en the clock rx_done fires for 8'hEE -> no overrun, full stays 1; drain yields 02..08 then EE.
- Reset mid-frame: assert rst during DATA bit 4 of 8'hFF, release -> empty=1, no write, no flags; next frame 8'h81 received intact.

Source files
------------

// File: rtl/uart_rx_path_if.sv
// Host-side FIFO read interface of the UART receive path.
interface uart_rx_path_if #(
  parameter int unsigned DBit = 8
);
  logic            read_en;
  logic [DBit-1:0] read_data;
  logic            empty;
  logic            full;

  // Host pops words and watches the flags.
  modport master (
    output read_en,
    input  read_data,
    input  empty,
    input  full
  );

  // Receive path presents the FIFO head and flags.
  modport slave (
    input  read_en,
    output read_data,
    output empty,
    output full
  );
endinterface

// File: rtl/uart_rx_path.sv
// UART receive path: baud-tick timer, 2-flop rx synchronizer, 16x oversampling
// receiver FSM and a first-word-fall-through receive FIFO.
module uart_rx_path #(
  parameter int unsigned Bit      = 10,
  parameter int unsigned DBit     = 8,
  parameter int unsigned StopTick = 16,
  parameter int unsigned Depth    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Bit-1:0]  input_number,
  input  logic            rx,
  output logic            frame_err,
  output logic            overrun,
  uart_rx_path_if.slave   rd_if
);

  // s must reach both 15 (data bit) and StopTick-1 (stop bit).
  localparam int unsigned SMax = (StopTick > 16) ? StopTick : 16;
  localparam int unsigned SW   = $clog2(SMax);
  localparam int unsigned NW   = $clog2(DBit);
  localparam int unsigned PW   = $clog2(Depth);
  localparam int unsigned CW   = PW + 1;

  localparam logic [SW-1:0] SMidStart = SW'(7);
  localparam logic [SW-1:0] SLastData = SW'(15);
  localparam logic [SW-1:0] SLastStop = SW'(StopTick - 1);
  localparam logic [NW-1:0] NLast     = NW'(DBit - 1);
  localparam logic [CW-1:0] CntFull   = CW'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Baud timer and input synchronizer
  // ---------------------------------------------------------------------------
  logic [Bit-1:0] cnt_q, cnt_d;
  logic           sync1_q, sync2_q;
  logic           s_tick;
  logic           rx_s;

  // Timer wraps at input_number; a new divisor is seen at the next compare.
  always_comb begin
    s_tick = (cnt_q == input_number);
    cnt_d  = s_tick ? '0 : cnt_q + 1'b1;
    rx_s   = sync2_q;
  end

  // Timer count and synchronizer flops; sync resets to line-idle (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBit-1:0] shift_q, shift_d;
  logic            rx_done;

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
    end
  end

  // Next state: sample mid start bit, then every 16 ticks per data bit.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SMidStart) begin
            if (rx_s) begin
              state_d = StIdle;  // glitch shorter than half a bit
            end else begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SLastData) begin
            shift_d = {rx_s, shift_q[DBit-1:1]};
            s_d     = '0;
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SLastStop) begin
            state_d = StIdle;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: done/error strobes on the final stop-bit sample.
  always_comb begin
    rx_done   = 1'b0;
    frame_err = 1'b0;
    if (state_q == StStop && s_tick && s_q == SLastStop) begin
      rx_done   = rx_s;
      frame_err = !rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [DBit-1:0] mem_q [Depth];
  logic [DBit-1:0] mem_d [Depth];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            rd_en, wr_en, at_full;

  // A pop frees the slot in the same clock, so full+read still accepts a write.
  always_comb begin
    at_full  = (count_q == CntFull);
    rd_en    = rd_if.read_en && (count_q != '0);
    wr_en    = rx_done && (!at_full || rd_en);
    overrun  = rx_done && at_full && !rd_en;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntFull);
    empty_d = (count_d == '0);
  end

  // FIFO storage, pointers, count and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Host-facing FIFO view.
  always_comb begin
    rd_if.read_data = mem_q[rd_ptr_q];
    rd_if.full      = full_q;
    rd_if.empty     = empty_q;
  end

endmodule
